// File: rtl/core_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package core_pkg;

  // Controller FSM: normal flow, or holding the pipe for a slow data access.
  typedef enum logic {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } state_t;

  // Architectural zero register; writes to it are discarded, so it never
  // creates a data dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 32;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and the stage-register controls.
//
// Handshake: dmem_req/dmem_ready is the only handshake here. An access
// presented in EX/MEM completes in the cycle where dmem_req and dmem_ready
// are both high; while dmem_req is high and dmem_ready is low, the pipe is
// frozen and the requester must keep dmem_req and its access stable.
interface hazard_ctrl_if #(parameter int CNT_W = core_pkg::CNT_W_DEF);

  // Hazard inputs, driven by the pipeline datapath.
  logic       IDEX_MemRead;
  logic [4:0] IDEX_rd;
  logic [4:0] IFID_rs1;
  logic [4:0] IFID_rs2;
  logic       branch_taken;
  logic       imem_ready;
  logic       dmem_req;
  logic       dmem_ready;

  // Controls and status, driven by the controller.
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic             EXMEM_flush;
  logic             pipe_hold;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             dmem_timeout;
  core_pkg::state_t state_dbg;

  modport master (
    output IDEX_MemRead, IDEX_rd, IFID_rs1, IFID_rs2,
    output branch_taken, imem_ready, dmem_req, dmem_ready,
    input  PCWrite, IFIDWrite, IFID_flush, IDEX_flush, EXMEM_flush, pipe_hold,
    input  stall_count, flush_count, dmem_timeout, state_dbg
  );

  modport slave (
    input  IDEX_MemRead, IDEX_rd, IFID_rs1, IFID_rs2,
    input  branch_taken, imem_ready, dmem_req, dmem_ready,
    output PCWrite, IFIDWrite, IFID_flush, IDEX_flush, EXMEM_flush, pipe_hold,
    output stall_count, flush_count, dmem_timeout, state_dbg
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count one event per cycle; hold once every bit is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use bubbles,
// taken-branch squashes, fetch bubbles and data-memory wait holds.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam int            WW    = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_V  = WW'(TIMEOUT);
  localparam logic [WW-1:0] ONE_V = WW'(1);

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;

  logic load_use;
  logic pc_we, ifid_we, ifid_fl, idex_fl, exmem_fl, hold;
  logic stall_inc, flush_inc;

  // A load whose destination feeds the next instruction; x0 is never a source
  // of a real dependency.
  assign load_use = bus.IDEX_MemRead && (bus.IDEX_rd != REG_ZERO) &&
                    ((bus.IDEX_rd == bus.IFID_rs1) || (bus.IDEX_rd == bus.IFID_rs2));

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state and zero-latency stage controls; the data wait outranks
  // everything because nothing may move while memory is busy.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    exmem_fl  = 1'b0;
    hold      = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (((state_q == RUN) && bus.dmem_req && !bus.dmem_ready) ||
        ((state_q == DWAIT) && !bus.dmem_ready)) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      hold      = 1'b1;
      stall_inc = 1'b1;
      state_d   = DWAIT;
      if (state_q == RUN) begin
        wait_d = ONE_V;
      end else if (wait_q == TO_V) begin
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      // Release cycle of a wait falls through to the normal rules, so a
      // branch held in the frozen EX/MEM is applied now.
      if (state_q == DWAIT) begin
        state_d = RUN;
        wait_d  = '0;
      end
      if (bus.branch_taken) begin
        ifid_fl   = 1'b1;
        idex_fl   = 1'b1;
        exmem_fl  = 1'b1;
        flush_inc = 1'b1;
      end else if (load_use) begin
        pc_we     = 1'b0;
        ifid_we   = 1'b0;
        idex_fl   = 1'b1;
        stall_inc = 1'b1;
      end else if (!bus.imem_ready) begin
        pc_we     = 1'b0;
        ifid_fl   = 1'b1;
        stall_inc = 1'b1;
      end
    end

    // Keep the pipeline quiet while reset is held.
    if (reset) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      ifid_fl  = 1'b0;
      idex_fl  = 1'b0;
      exmem_fl = 1'b0;
      hold     = 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (bus.stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (bus.flush_count)
  );

  assign bus.PCWrite      = pc_we;
  assign bus.IFIDWrite    = ifid_we;
  assign bus.IFID_flush   = ifid_fl;
  assign bus.IDEX_flush   = idex_fl;
  assign bus.EXMEM_flush  = exmem_fl;
  assign bus.pipe_hold    = hold;
  assign bus.dmem_timeout = timeout_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default sizes, and TIMEOUT=3 with
// 4-bit counters) share one stimulus stream and are checked every cycle
// against an event-level model, plus directed literal checks.
module tb_hazard_ctrl;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       idex_memread;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic       branch_taken, imem_ready, dmem_req, dmem_ready;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl_if #(.CNT_W(32)) ifa ();
  hazard_ctrl_if #(.CNT_W(4))  ifb ();

  hazard_ctrl #(.TIMEOUT(255), .CNT_W(32)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  hazard_ctrl #(.TIMEOUT(3),   .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  assign ifa.IDEX_MemRead = idex_memread;
  assign ifa.IDEX_rd      = idex_rd;
  assign ifa.IFID_rs1     = ifid_rs1;
  assign ifa.IFID_rs2     = ifid_rs2;
  assign ifa.branch_taken = branch_taken;
  assign ifa.imem_ready   = imem_ready;
  assign ifa.dmem_req     = dmem_req;
  assign ifa.dmem_ready   = dmem_ready;
  assign ifb.IDEX_MemRead = idex_memread;
  assign ifb.IDEX_rd      = idex_rd;
  assign ifb.IFID_rs1     = ifid_rs1;
  assign ifb.IFID_rs2     = ifid_rs2;
  assign ifb.branch_taken = branch_taken;
  assign ifb.imem_ready   = imem_ready;
  assign ifb.dmem_req     = dmem_req;
  assign ifb.dmem_ready   = dmem_ready;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Per instance: is a data wait in progress, how many held cycles so far in
  // this wait episode, event totals (saturated), and the sticky flag.
  longint m_tmo[2]  = '{255, 3};
  longint m_cmax[2] = '{64'hFFFF_FFFF, 15};
  bit     m_dwait[2] = '{0, 0};
  longint m_held[2]  = '{0, 0};
  longint m_stall[2] = '{0, 0};
  longint m_flush[2] = '{0, 0};
  bit     m_to[2]    = '{0, 0};

  bit     n_dwait[2];
  longint n_held[2], n_stall[2], n_flush[2];
  bit     n_to[2];

  // Compare every cycle on the falling edge, then work out the model's
  // state for after the next rising edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [5:0]  exp_v, act_v;
      logic [63:0] act_sc, act_fc;
      logic        act_to, act_st;
      bit          waiting, lu, stall_evt, flush_evt;

      act_v  = (k == 0) ? {ifa.PCWrite, ifa.IFIDWrite, ifa.IFID_flush, ifa.IDEX_flush, ifa.EXMEM_flush, ifa.pipe_hold}
                        : {ifb.PCWrite, ifb.IFIDWrite, ifb.IFID_flush, ifb.IDEX_flush, ifb.EXMEM_flush, ifb.pipe_hold};
      act_sc = (k == 0) ? 64'(ifa.stall_count) : 64'(ifb.stall_count);
      act_fc = (k == 0) ? 64'(ifa.flush_count) : 64'(ifb.flush_count);
      act_to = (k == 0) ? ifa.dmem_timeout : ifb.dmem_timeout;
      act_st = (k == 0) ? (ifa.state_dbg == DWAIT) : (ifb.state_dbg == DWAIT);

      waiting = m_dwait[k] ? !dmem_ready : (dmem_req && !dmem_ready);
      lu = idex_memread && (idex_rd != 5'd0) && ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

      // {PCWrite, IFIDWrite, IFID_flush, IDEX_flush, EXMEM_flush, pipe_hold}
      if (reset)              exp_v = 6'b000000;
      else if (waiting)       exp_v = 6'b000001;
      else if (branch_taken)  exp_v = 6'b111110;
      else if (lu)            exp_v = 6'b000100;
      else if (!imem_ready)   exp_v = 6'b011000;
      else                    exp_v = 6'b110000;

      check($sformatf("model_ctrl[%0d]", k), 64'(act_v), 64'(exp_v));
      check($sformatf("model_stall[%0d]", k), act_sc, m_stall[k]);
      check($sformatf("model_flush[%0d]", k), act_fc, m_flush[k]);
      check($sformatf("model_timeout[%0d]", k), 64'(act_to), 64'(m_to[k]));
      check($sformatf("model_dwait[%0d]", k), 64'(act_st), 64'(m_dwait[k]));

      stall_evt = waiting || (!branch_taken && (lu || !imem_ready));
      flush_evt = !waiting && branch_taken;
      if (reset) begin
        n_dwait[k] = 0; n_held[k] = 0; n_stall[k] = 0; n_flush[k] = 0; n_to[k] = 0;
      end else begin
        n_dwait[k] = waiting;
        n_held[k]  = waiting ? m_held[k] + 1 : 0;
        n_stall[k] = (stall_evt && m_stall[k] < m_cmax[k]) ? m_stall[k] + 1 : m_stall[k];
        n_flush[k] = (flush_evt && m_flush[k] < m_cmax[k]) ? m_flush[k] + 1 : m_flush[k];
        n_to[k]    = m_to[k] || (waiting && (m_held[k] + 1 >= m_tmo[k] + 1));
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_dwait[k] <= 0; m_held[k] <= 0; m_stall[k] <= 0; m_flush[k] <= 0; m_to[k] <= 0;
      end else begin
        m_dwait[k] <= n_dwait[k]; m_held[k] <= n_held[k]; m_stall[k] <= n_stall[k];
        m_flush[k] <= n_flush[k]; m_to[k] <= n_to[k];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    idex_memread = 1'b0; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    branch_taken = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    set_idle();
    repeat (2) @(posedge clk);
    mid_cycle();
    check("rst_pcwrite", 64'(ifa.PCWrite), 64'd0);
    check("rst_ifidwrite", 64'(ifa.IFIDWrite), 64'd0);
    check("rst_stall_count", 64'(ifa.stall_count), 64'd0);
    check("rst_state", 64'(ifa.state_dbg), 64'(RUN));
    next_cycle();
    reset = 1'b0;

    // Load-use on rs2, then the same with rd = x0.
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5;
    mid_cycle();
    check("lu_ctrl", 64'({ifa.PCWrite, ifa.IFIDWrite, ifa.IDEX_flush}), 64'(3'b001));
    next_cycle();
    set_idle();
    mid_cycle();
    check("lu_stall_count", 64'(ifa.stall_count), 64'd1);
    check("lu_release_pcwrite", 64'(ifa.PCWrite), 64'd1);
    next_cycle();
    idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
    mid_cycle();
    check("x0_ctrl", 64'({ifa.PCWrite, ifa.IFIDWrite, ifa.IDEX_flush}), 64'(3'b110));
    next_cycle();
    set_idle();
    mid_cycle();
    check("x0_stall_count", 64'(ifa.stall_count), 64'd1);

    // Branch and load-use together: only the squash happens.
    next_cycle();
    branch_taken = 1'b1; idex_memread = 1'b1; idex_rd = 5'd3; ifid_rs1 = 5'd3;
    mid_cycle();
    check("br_lu_ctrl", 64'({ifa.PCWrite, ifa.IFIDWrite, ifa.IFID_flush, ifa.IDEX_flush,
                            ifa.EXMEM_flush, ifa.pipe_hold}), 64'(6'b111110));
    next_cycle();
    set_idle();
    mid_cycle();
    check("br_flush_count", 64'(ifa.flush_count), 64'd1);
    check("br_stall_count", 64'(ifa.stall_count), 64'd1);

    // Four-cycle data wait, released in the fifth.
    next_cycle();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid_cycle();
      check($sformatf("dw_hold_%0d", i), 64'(ifa.pipe_hold), 64'd1);
      next_cycle();
    end
    dmem_ready = 1'b1;
    mid_cycle();
    check("dw_release", 64'({ifa.pipe_hold, ifa.PCWrite}), 64'(2'b01));
    next_cycle();
    set_idle();
    mid_cycle();
    check("dw_stall_count", 64'(ifa.stall_count), 64'd5);
    check("dw_state", 64'(ifa.state_dbg), 64'(RUN));

    // Timeout on the TIMEOUT=3 instance.
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      mid_cycle();
      if (i == 4) check("to_before", 64'(ifb.dmem_timeout), 64'd0);
      if (i == 5) check("to_set", 64'(ifb.dmem_timeout), 64'd1);
      if (i == 6) check("to_a_clear", 64'(ifa.dmem_timeout), 64'd0);
      next_cycle();
    end
    dmem_ready = 1'b1;
    mid_cycle();
    check("to_release", 64'({ifb.pipe_hold, ifb.dmem_timeout}), 64'(2'b01));
    next_cycle();
    set_idle();
    mid_cycle();
    check("to_sticky", 64'(ifb.dmem_timeout), 64'd1);
    check("to_state", 64'(ifb.state_dbg), 64'(RUN));
    next_cycle();
    reset = 1'b1;
    mid_cycle();
    check("to_reset_clear", 64'(ifb.dmem_timeout), 64'd0);
    next_cycle();
    reset = 1'b0;

    // Branch held during a wait: squash only on release.
    dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid_cycle();
      check($sformatf("bw_noflush_%0d", i), 64'({ifa.IFID_flush, ifa.IDEX_flush, ifa.EXMEM_flush}), 64'd0);
      next_cycle();
    end
    dmem_ready = 1'b1;
    mid_cycle();
    check("bw_release_flush", 64'({ifa.IFID_flush, ifa.IDEX_flush, ifa.EXMEM_flush, ifa.PCWrite}),
          64'(4'b1111));
    next_cycle();
    set_idle();
    mid_cycle();
    check("bw_flush_count", 64'(ifa.flush_count), 64'd1);
    check("bw_stall_count", 64'(ifa.stall_count), 64'd3);

    // Asynchronous reset in the middle of a wait.
    next_cycle();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("ar_state", 64'(ifa.state_dbg), 64'(RUN));
    check("ar_counts", {ifa.stall_count, ifa.flush_count}, 64'd0);
    check("ar_ctrl", 64'({ifa.PCWrite, ifa.IFIDWrite, ifa.pipe_hold}), 64'd0);
    next_cycle();
    reset = 1'b0;
    set_idle();

    // Saturation: 20 fetch bubbles into a 4-bit counter.
    imem_ready = 1'b0;
    repeat (20) next_cycle();
    set_idle();
    mid_cycle();
    check("sat_b_stall", 64'(ifb.stall_count), 64'd15);
    check("sat_a_stall", 64'(ifa.stall_count), 64'd20);
    #2;
    reset = 1'b1;
    #1;
    check("sat_b_reset", 64'(ifb.stall_count), 64'd0);
    next_cycle();
    reset = 1'b0;
    repeat (2) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It drives the IF/ID write-enable and flush, the PC write-enable, and the ID/EX and EX/MEM flush and hold controls. It resolves load-use hazards, taken-branch flushes, instruction-memory bubbles and multi-cycle data-memory waits. It also keeps saturating stall and flush statistics, plus a sticky data-memory timeout flag.

## Interface
- TIMEOUT, 255: number of DWAIT cycles after which dmem_timeout is set.
- CNT_W, 32: width of the statistics counters.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- IDEX_MemRead  in  1  instruction in ID/EX is a load.
- IDEX_rd  in  5  destination register of the ID/EX instruction.
- IFID_rs1, IFID_rs2  in  5 each  source registers of the IF/ID instruction.
- branch_taken  in  1  taken branch/jump resolved in EX/MEM.
- imem_ready  in  1  instruction fetch data is valid this cycle.
- dmem_req  in  1  EX/MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC register enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFID_flush, IDEX_flush, EXMEM_flush  out  1 each  zero the instruction or control fields of that stage register.
- pipe_hold  out  1  freezes ID/EX, EX/MEM and MEM/WB.
- stall_count, flush_count  out  CNT_W each  statistics counters.
- dmem_timeout  out  1  sticky error flag.

## Operation
- States: RUN and DWAIT. State, wait counter, statistics counters and dmem_timeout are registered. All control outputs are combinational from state and the current inputs.
- Default outputs: PCWrite=1, IFIDWrite=1, all flush signals 0, pipe_hold=0.
- RUN: rules are evaluated in priority order and the first match wins.
  1. Data-memory wait, when dmem_req & ~dmem_ready:
     - PCWrite=0, IFIDWrite=0, pipe_hold=1, no flushes.
     - Next state DWAIT; wait counter loads 1; stall_count increments.
  2. Branch flush, when branch_taken:
     - IFID_flush=1, IDEX_flush=1, EXMEM_flush=1; PC and IF/ID enables stay 1.
     - flush_count increments.
     - Overrides load-use, because the dependent instruction is squashed.
  3. Load-use stall, when IDEX_MemRead & IDEX_rd≠0 & (IDEX_rd==IFID_rs1 | IDEX_rd==IFID_rs2):
     - PCWrite=0, IFIDWrite=0, IDEX_flush=1 (bubble).
     - stall_count increments.
  4. Fetch bubble, when ~imem_ready:
     - PCWrite=0, IFIDWrite=1, IFID_flush=1.
     - stall_count increments.
  5. Otherwise: default outputs.
- DWAIT with ~dmem_ready:
  - Same outputs as rule 1; stall_count increments.
  - Wait counter increments, saturating at TIMEOUT.
  - When the counter equals TIMEOUT, dmem_timeout is set. It stays set until reset; the FSM remains in DWAIT.
- DWAIT with dmem_ready:
  - pipe_hold=0; outputs follow RUN rules 2–5 for this cycle.
  - Next state RUN; wait counter cleared.
  - A branch_taken that was held steady by the frozen EX/MEM is applied in this release cycle.
- Counters saturate at all-ones and never wrap.
- Register x0 never causes a load-use stall.

## Timing
- Reset values: state RUN, wait counter 0, stall_count 0, flush_count 0, dmem_timeout 0.
- While reset is high, outputs are forced to PCWrite=0, IFIDWrite=0, all flush signals 0, pipe_hold=0.
- Control outputs have zero latency: they respond in the same cycle as their inputs.
- Statistics and dmem_timeout update on the following edge.
- A load-use stall lasts exactly 1 cycle, because the inserted bubble removes the hazard.
- A data-memory wait lasting N cycles holds the pipe for N cycles. The release happens in the cycle dmem_ready is high.
- Reset asserted mid-DWAIT: immediate return to RUN; counters and the timeout flag are cleared.

## Structure
- Shared package core_pkg holds:
  - state enum: RUN=1'b0, DWAIT=1'b1
  - REG_ZERO = 5'd0
  - default TIMEOUT and CNT_W constants
- Natural sub-module: sat_counter (parameter CNT_W; ports clk, reset, inc, count). It is instantiated twice, for stall_count and flush_count.

## Test plan
- Load-use: IDEX_MemRead=1, IDEX_rd=5, IFID_rs2=5 → one cycle of PCWrite=0, IFIDWrite=0, IDEX_flush=1; stall_count 0→1. Repeat with IDEX_rd=0 → no stall.
- Branch plus load-use in the same cycle → only the flush outputs assert (IFID_flush, IDEX_flush, EXMEM_flush); PCWrite=1; flush_count=1; stall_count unchanged.
- dmem_req=1 with dmem_ready low for 4 cycles → pipe_hold=1 for 4 cycles and released in cycle 5; stall_count=4; state back in RUN.
- TIMEOUT=3, dmem_ready never asserted → dmem_timeout=1 after the 3rd DWAIT cycle and stays 1. Asserting dmem_ready releases the pipe with the flag still 1; reset clears it.
- branch_taken held during DWAIT → no flush outputs until the release cycle, then all three flush signals assert once.
- Reset pulse mid-DWAIT plus saturation: force a counter to all-ones with CNT_W=4 → it stays 15. Reset → all outputs and counters return to their reset values asynchronously.
